// File: rtl/serial2parallel_pkg.sv
// Shared helpers for the serial2parallel receive path.
package serial2parallel_pkg;

    // Number of bits needed to hold the unsigned value 'value' (at least 1).
    function automatic int get_width(input int value);
        int width;
        width = 1;
        for (int i = 1; i < 31; i++) begin
            if ((value >>> i) != 0) begin
                width = i + 1;
            end else begin
                width = width;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer bringing one asynchronous line into the clk domain.
module bit_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage metastability filter, cleared by the async active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/serial2parallel.sv
// Receive end of the s_clk/s_clr/s_dat serial link. The serial lines are
// synchronized into clk, s_clk rising edges shift bits into a word, and every
// DATA_BITS bits the word is published on data with a one-cycle valid pulse.
// A frame is aborted by s_clr or by a stalled s_clk; both pulse error when a
// partial frame is thrown away.
module serial2parallel
    import serial2parallel_pkg::*;
#(
    parameter int P_CLK_FREQ  = 100,
    parameter int S_CLK_FREQ  = 20,
    parameter int DATA_BITS   = 64,
    parameter int CODE_ENDIAN = 1,
    parameter int TIMEOUT     = 8 * P_CLK_FREQ / S_CLK_FREQ
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_clk,
    input  logic                 s_clr,
    input  logic                 s_dat,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 busy,
    output logic                 error
);

    localparam int CNT_W  = get_width(DATA_BITS);
    localparam int IDLE_W = get_width(TIMEOUT);

    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_BITS - 1);
    localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = {IDLE_W{1'b1}};
    localparam logic [1:0]        ARM_DONE  = 2'd3;

    // Synchronized serial lines and edge detection.
    logic s_clk_sync_s;
    logic s_dat_sync_s;
    logic s_clr_sync_s;
    logic s_clk_d3_r;
    logic [1:0] arm_cnt_r;
    logic arm_done_s;
    logic rise_s;

    // Frame assembly state.
    logic [DATA_BITS-1:0] shift_r;
    logic [CNT_W-1:0]     bit_cnt_r;
    logic [IDLE_W-1:0]    idle_cnt_r;
    logic [DATA_BITS-1:0] data_r;
    logic                 valid_r;
    logic                 error_r;
    logic                 busy_r;

    // Next-state values.
    logic [DATA_BITS-1:0] full_word_s;
    logic [DATA_BITS-1:0] shift_nxt_s;
    logic [CNT_W-1:0]     bit_cnt_nxt_s;
    logic [IDLE_W-1:0]    idle_cnt_nxt_s;
    logic [DATA_BITS-1:0] data_nxt_s;
    logic                 valid_nxt_s;
    logic                 error_nxt_s;
    logic                 busy_s;

    bit_sync u_sync_clk (
        .clk (clk),
        .rst (rst),
        .d   (s_clk),
        .q   (s_clk_sync_s)
    );

    bit_sync u_sync_dat (
        .clk (clk),
        .rst (rst),
        .d   (s_dat),
        .q   (s_dat_sync_s)
    );

    bit_sync u_sync_clr (
        .clk (clk),
        .rst (rst),
        .d   (s_clr),
        .q   (s_clr_sync_s)
    );

    // Third s_clk stage for edge detection, and the post-reset arming counter
    // that hides the apparent edge of a line already high at reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_clk_d3_r <= 1'b0;
            arm_cnt_r  <= 2'd0;
        end else begin
            s_clk_d3_r <= s_clk_sync_s;
            if (arm_cnt_r != ARM_DONE) begin
                arm_cnt_r <= arm_cnt_r + 2'd1;
            end else begin
                arm_cnt_r <= arm_cnt_r;
            end
        end
    end

    assign arm_done_s = (arm_cnt_r == ARM_DONE);
    assign rise_s     = s_clk_sync_s & ~s_clk_d3_r & arm_done_s;
    assign busy_s     = (bit_cnt_r != '0);

    // Shift register with the newest bit merged in, in the configured bit order.
    always_comb begin
        full_word_s = shift_r;
        if (CODE_ENDIAN != 0) begin
            full_word_s = {shift_r[DATA_BITS-2:0], s_dat_sync_s};
        end else begin
            full_word_s = {s_dat_sync_s, shift_r[DATA_BITS-1:1]};
        end
    end

    // Frame control: clear beats a rise, a rise beats the stall timeout.
    always_comb begin
        shift_nxt_s    = shift_r;
        bit_cnt_nxt_s  = bit_cnt_r;
        idle_cnt_nxt_s = idle_cnt_r;
        data_nxt_s     = data_r;
        valid_nxt_s    = 1'b0;
        error_nxt_s    = 1'b0;
        if (s_clr_sync_s) begin
            shift_nxt_s    = '0;
            bit_cnt_nxt_s  = '0;
            idle_cnt_nxt_s = '0;
            error_nxt_s    = busy_s;
        end else if (rise_s) begin
            idle_cnt_nxt_s = '0;
            if (bit_cnt_r == LAST_BIT) begin
                data_nxt_s    = full_word_s;
                valid_nxt_s   = 1'b1;
                shift_nxt_s   = '0;
                bit_cnt_nxt_s = '0;
            end else begin
                shift_nxt_s   = full_word_s;
                bit_cnt_nxt_s = bit_cnt_r + CNT_ONE;
            end
        end else if (busy_s && (idle_cnt_r == IDLE_LAST)) begin
            shift_nxt_s    = '0;
            bit_cnt_nxt_s  = '0;
            idle_cnt_nxt_s = '0;
            error_nxt_s    = 1'b1;
        end else if (busy_s) begin
            if (idle_cnt_r != IDLE_MAX) begin
                idle_cnt_nxt_s = idle_cnt_r + IDLE_ONE;
            end else begin
                idle_cnt_nxt_s = idle_cnt_r;
            end
        end else begin
            idle_cnt_nxt_s = '0;
        end
    end

    // Frame state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_r    <= '0;
            bit_cnt_r  <= '0;
            idle_cnt_r <= '0;
            data_r     <= '0;
            valid_r    <= 1'b0;
            error_r    <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            shift_r    <= shift_nxt_s;
            bit_cnt_r  <= bit_cnt_nxt_s;
            idle_cnt_r <= idle_cnt_nxt_s;
            data_r     <= data_nxt_s;
            valid_r    <= valid_nxt_s;
            error_r    <= error_nxt_s;
            busy_r     <= (bit_cnt_nxt_s != '0);
        end
    end

    assign data  = data_r;
    assign valid = valid_r;
    assign busy  = busy_r;
    assign error = error_r;

endmodule

// File: tb/tb_serial2parallel.sv
// Self-checking bench for serial2parallel: two 16-bit receivers (MSB-first and
// LSB-first) share one serial link, a 64-bit receiver gets a loopback stream.
module tb_serial2parallel;

    localparam int TIMEOUT16 = 40;

    logic clk;
    logic rst;
    logic a_clk, a_clr, a_dat;
    logic b_clk, b_clr, b_dat;

    logic [15:0] msb_data, lsb_data;
    logic        msb_valid, msb_busy, msb_error;
    logic        lsb_valid, lsb_busy, lsb_error;
    logic [63:0] wide_data;
    logic        wide_valid, wide_busy, wide_error;

    int n_checks;
    int n_pass;
    int msb_vcnt, msb_ecnt, lsb_vcnt, lsb_ecnt, wide_vcnt, wide_ecnt, both_cnt;
    logic [15:0] msb_q[$];
    logic [15:0] lsb_q[$];
    logic [63:0] wide_q[$];

    serial2parallel #(.DATA_BITS(16), .CODE_ENDIAN(1)) u_msb (
        .clk(clk), .rst(rst), .s_clk(a_clk), .s_clr(a_clr), .s_dat(a_dat),
        .data(msb_data), .valid(msb_valid), .busy(msb_busy), .error(msb_error)
    );

    serial2parallel #(.DATA_BITS(16), .CODE_ENDIAN(0)) u_lsb (
        .clk(clk), .rst(rst), .s_clk(a_clk), .s_clr(a_clr), .s_dat(a_dat),
        .data(lsb_data), .valid(lsb_valid), .busy(lsb_busy), .error(lsb_error)
    );

    serial2parallel #(.DATA_BITS(64), .CODE_ENDIAN(1)) u_wide (
        .clk(clk), .rst(rst), .s_clk(b_clk), .s_clr(b_clr), .s_dat(b_dat),
        .data(wide_data), .valid(wide_valid), .busy(wide_busy), .error(wide_error)
    );

    // 100 MHz main clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pulse counters and captured words, sampled away from the active edge.
    always @(negedge clk) begin
        if (msb_valid)  begin msb_vcnt  <= msb_vcnt + 1;  msb_q.push_back(msb_data);   end
        if (lsb_valid)  begin lsb_vcnt  <= lsb_vcnt + 1;  lsb_q.push_back(lsb_data);   end
        if (wide_valid) begin wide_vcnt <= wide_vcnt + 1; wide_q.push_back(wide_data); end
        if (msb_error)  msb_ecnt  <= msb_ecnt + 1;
        if (lsb_error)  lsb_ecnt  <= lsb_ecnt + 1;
        if (wide_error) wide_ecnt <= wide_ecnt + 1;
        if ((msb_valid && msb_error) || (lsb_valid && lsb_error) || (wide_valid && wide_error))
            both_cnt <= both_cnt + 1;
    end

    // Reference: word assembled from a bit stream. Bit i of the stream is taken
    // from the sent word in the send order; the receiver places it either by
    // shifting left (first bit ends up at the top) or at weight 2**i.
    function automatic logic [63:0] model_word(input logic [63:0] word, input int n,
                                               input bit send_msb, input bit recv_msb);
        logic [63:0] acc;
        logic        b;
        acc = 64'd0;
        for (int i = 0; i < n; i++) begin
            b = send_msb ? word[n-1-i] : word[i];
            if (recv_msb) acc = (acc << 1) | {63'd0, b};
            else          acc = acc | ({63'd0, b} << i);
        end
        return acc;
    endfunction

    task automatic idle_clks(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    // Send n bits of word on link a at 20 MHz; s_clk is left high.
    task automatic send_a(input logic [63:0] word, input int n, input bit msb_first);
        for (int i = 0; i < n; i++) begin
            a_clk = 1'b0;
            a_dat = msb_first ? word[n-1-i] : word[i];
            #25;
            a_clk = 1'b1;
            #25;
        end
    endtask

    task automatic send_b(input logic [63:0] word, input int n);
        for (int i = 0; i < n; i++) begin
            b_clk = 1'b0;
            b_dat = word[n-1-i];
            #25;
            b_clk = 1'b1;
            #25;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        a_clk = 1'b0; a_clr = 1'b0; a_dat = 1'b0;
        b_clk = 1'b0; b_clr = 1'b0; b_dat = 1'b0;
        #23;
        n_checks++; if (msb_data !== 16'h0000) $display("FAIL reset_data: got %h want 0000", msb_data); else n_pass++;
        n_checks++; if ({msb_valid, msb_busy, msb_error, lsb_valid, lsb_busy, lsb_error} !== 6'b0)
            $display("FAIL reset_flags: got %b want 000000", {msb_valid, msb_busy, msb_error, lsb_valid, lsb_busy, lsb_error}); else n_pass++;
        n_checks++; if (wide_data !== 64'd0) $display("FAIL reset_wide_data: got %h want 0", wide_data); else n_pass++;
        idle_clks(1);
        rst = 1'b1;
        idle_clks(5);
    endtask

    task automatic test_msb_first;
        int v0, e0;
        logic [15:0] exp_lsb;
        v0 = msb_vcnt; e0 = msb_ecnt;
        exp_lsb = model_word(64'hA5C3, 16, 1'b1, 1'b0);
        send_a(64'hA5C3, 16, 1'b1);
        a_clk = 1'b0;
        idle_clks(8);
        n_checks++; if (msb_data !== 16'hA5C3) $display("FAIL msb_data: got %h want a5c3", msb_data); else n_pass++;
        n_checks++; if (msb_vcnt - v0 !== 1) $display("FAIL msb_valid_count: got %0d want 1", msb_vcnt - v0); else n_pass++;
        n_checks++; if (msb_ecnt - e0 !== 0) $display("FAIL msb_no_error: got %0d want 0", msb_ecnt - e0); else n_pass++;
        n_checks++; if (lsb_data !== exp_lsb || lsb_data !== 16'hC3A5) $display("FAIL lsb_on_msb_stream: got %h want %h", lsb_data, exp_lsb); else n_pass++;
        n_checks++; if (msb_busy !== 1'b0) $display("FAIL msb_busy_after: got %b want 0", msb_busy); else n_pass++;
    endtask

    task automatic test_lsb_first;
        send_a(64'hA5C3, 16, 1'b0);
        a_clk = 1'b0;
        idle_clks(8);
        n_checks++; if (lsb_data !== 16'hA5C3) $display("FAIL lsb_data: got %h want a5c3", lsb_data); else n_pass++;
        n_checks++; if (msb_data !== 16'hC3A5) $display("FAIL msb_on_lsb_stream: got %h want c3a5", msb_data); else n_pass++;
        send_a(64'h3CA5, 16, 1'b0);
        a_clk = 1'b0;
        idle_clks(8);
        n_checks++; if (lsb_data !== 16'h3CA5) $display("FAIL lsb_swapped: got %h want 3ca5", lsb_data); else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [15:0] words[6];
        msb_q.delete(); lsb_q.delete();
        for (int i = 0; i < 6; i++) words[i] = 16'($urandom);
        for (int i = 0; i < 6; i++) send_a({48'd0, words[i]}, 16, 1'b1);
        a_clk = 1'b0;
        idle_clks(8);
        n_checks++; if (msb_q.size() !== 6 || lsb_q.size() !== 6)
            $display("FAIL b2b_count: got %0d/%0d want 6", msb_q.size(), lsb_q.size()); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            if (i < msb_q.size() && i < lsb_q.size()) begin
                n_checks++; if (msb_q[i] !== model_word({48'd0, words[i]}, 16, 1'b1, 1'b1) || msb_q[i] !== words[i])
                    $display("FAIL b2b_msb[%0d]: got %h want %h", i, msb_q[i], words[i]); else n_pass++;
                n_checks++; if (lsb_q[i] !== 16'(model_word({48'd0, words[i]}, 16, 1'b1, 1'b0)))
                    $display("FAIL b2b_lsb[%0d]: got %h want %h", i, lsb_q[i], 16'(model_word({48'd0, words[i]}, 16, 1'b1, 1'b0))); else n_pass++;
            end
        end
    endtask

    task automatic test_clear_abort;
        int v0, e0;
        logic [15:0] prev;
        prev = msb_data;
        v0 = msb_vcnt; e0 = msb_ecnt;
        send_a(64'($urandom), 7, 1'b1);
        idle_clks(4);
        n_checks++; if (msb_busy !== 1'b1) $display("FAIL clr_busy_before: got %b want 1", msb_busy); else n_pass++;
        a_clr = 1'b1;
        idle_clks(20);
        a_clr = 1'b0;
        idle_clks(5);
        n_checks++; if (msb_ecnt - e0 !== 1) $display("FAIL clr_error_once: got %0d want 1", msb_ecnt - e0); else n_pass++;
        n_checks++; if (msb_data !== prev) $display("FAIL clr_data_held: got %h want %h", msb_data, prev); else n_pass++;
        n_checks++; if (msb_busy !== 1'b0 || msb_vcnt !== v0) $display("FAIL clr_state: got busy=%b valid_count=%0d want 0/%0d", msb_busy, msb_vcnt, v0); else n_pass++;
        send_a(64'h0001, 16, 1'b1);
        a_clk = 1'b0;
        idle_clks(8);
        n_checks++; if (msb_data !== 16'h0001) $display("FAIL clr_next_frame: got %h want 0001", msb_data); else n_pass++;
    endtask

    task automatic test_timeout;
        int e0;
        logic [15:0] w;
        e0 = msb_ecnt;
        send_a(64'($urandom), 5, 1'b1);
        idle_clks(3);
        n_checks++; if (msb_busy !== 1'b1) $display("FAIL to_busy_before: got %b want 1", msb_busy); else n_pass++;
        idle_clks(TIMEOUT16 - 15);
        n_checks++; if (msb_ecnt !== e0 || msb_busy !== 1'b1)
            $display("FAIL to_early: got errors=%0d busy=%b want %0d/1", msb_ecnt, msb_busy, e0); else n_pass++;
        idle_clks(20);
        n_checks++; if (msb_ecnt - e0 !== 1) $display("FAIL to_error: got %0d want 1", msb_ecnt - e0); else n_pass++;
        n_checks++; if (msb_busy !== 1'b0 || lsb_busy !== 1'b0) $display("FAIL to_busy_after: got %b%b want 00", msb_busy, lsb_busy); else n_pass++;
        w = 16'($urandom);
        send_a({48'd0, w}, 16, 1'b1);
        a_clk = 1'b0;
        idle_clks(8);
        n_checks++; if (msb_data !== w) $display("FAIL to_next_frame: got %h want %h", msb_data, w); else n_pass++;
    endtask

    task automatic test_reset_edge;
        logic [15:0] w;
        rst = 1'b0;
        a_clk = 1'b1;
        b_clk = 1'b1;
        idle_clks(3);
        rst = 1'b1;
        idle_clks(10);
        n_checks++; if ({msb_busy, lsb_busy, wide_busy} !== 3'b000)
            $display("FAIL arm_busy: got %b want 000", {msb_busy, lsb_busy, wide_busy}); else n_pass++;
        a_clk = 1'b0;
        b_clk = 1'b0;
        idle_clks(3);
        send_a({48'd0, 16'($urandom)}, 6, 1'b1);
        idle_clks(3);
        n_checks++; if (msb_busy !== 1'b1) $display("FAIL mid_busy: got %b want 1", msb_busy); else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++; if ({msb_data, lsb_data} !== 32'd0) $display("FAIL mid_rst_data: got %h %h want 0", msb_data, lsb_data); else n_pass++;
        n_checks++; if ({msb_valid, msb_busy, msb_error, lsb_busy} !== 4'b0)
            $display("FAIL mid_rst_flags: got %b want 0000", {msb_valid, msb_busy, msb_error, lsb_busy}); else n_pass++;
        idle_clks(3);
        rst = 1'b1;
        idle_clks(5);
        w = 16'($urandom);
        send_a({48'd0, w}, 16, 1'b1);
        a_clk = 1'b0;
        idle_clks(8);
        n_checks++; if (msb_data !== w) $display("FAIL post_rst_frame: got %h want %h", msb_data, w); else n_pass++;
    endtask

    task automatic test_loopback;
        logic [63:0] exp_q[$];
        logic [63:0] w;
        int e0;
        wide_q.delete();
        e0 = wide_ecnt;
        for (int i = 0; i < 100; i++) begin
            w = {$urandom, $urandom};
            exp_q.push_back(model_word(w, 64, 1'b1, 1'b1));
            send_b(w, 64);
        end
        b_clk = 1'b0;
        idle_clks(10);
        n_checks++; if (wide_q.size() !== 100) $display("FAIL loop_count: got %0d want 100", wide_q.size()); else n_pass++;
        n_checks++; if (wide_ecnt !== e0) $display("FAIL loop_errors: got %0d want %0d", wide_ecnt, e0); else n_pass++;
        for (int i = 0; i < 100; i++) begin
            if (i < wide_q.size()) begin
                n_checks++; if (wide_q[i] !== exp_q[i]) $display("FAIL loop_word[%0d]: got %h want %h", i, wide_q[i], exp_q[i]); else n_pass++;
            end
        end
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        msb_vcnt = 0; msb_ecnt = 0; lsb_vcnt = 0; lsb_ecnt = 0;
        wide_vcnt = 0; wide_ecnt = 0; both_cnt = 0;
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_back_to_back();
        test_clear_abort();
        test_timeout();
        test_reset_edge();
        test_loopback();
        n_checks++; if (both_cnt !== 0) $display("FAIL valid_error_overlap: got %0d want 0", both_cnt); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
